servo_loop_sequencer: RTL and testbench
=======================================

// Module: servo_loop_sequencer
// PURPOSE
//  Sequences one closed-loop servo sample: periodic sample tick -> ADC conversion handshake ->
//  one-cycle update strobe to the IPD controller datapath -> saturation/scaling of its signed
//  output -> PWM duty load. Sits between the position ADC interface, the IPD block and the PWM.
// PARAMETERS
//  CANT_BITS     20     width of r/y samples; controller output is 2*CANT_BITS signed
//  DUTY_BITS     12     PWM duty width (unsigned)
//  DIV_MUESTREO  50000  clk cycles per sample period (>=8)
//  SHIFT         4      arithmetic right shift applied to controller output
//  OFFSET        2048   duty offset added after shift (neutral servo position)
//  TIMEOUT_CYC   1000   ADC wait limit in cycles (used only with SERVO_SEQ_TIMEOUT_EN)
// PORTS
//  clk          in   1            system clock
//  rst          in   1            reset, asynchronous, active-high
//  enable       in   1            run loop; 0 = abort to IDLE, clear sticky flags
//  ref_in       in   CANT_BITS    signed setpoint, sampled with ADC result
//  adc_start    out  1            one-cycle conversion request
//  adc_done     in   1            one-cycle conversion complete; adc_data valid same cycle
//  adc_data     in   CANT_BITS    signed measured position
//  pid_r        out  CANT_BITS    registered setpoint to controller
//  pid_y        out  CANT_BITS    registered measurement to controller
//  pid_listo    out  1            one-cycle update strobe to controller
//  pid_suma     in   2*CANT_BITS  signed controller output (registered inside controller)
//  duty         out  DUTY_BITS    saturated duty command
//  duty_load    out  1            one-cycle strobe, duty valid same cycle
//  busy         out  1            high in any state other than IDLE/WAIT_TICK
//  overrun      out  1            sticky: tick arrived while a sample was in progress
//  timeout_err  out  1            sticky: ADC did not answer (0 when feature compiled out)
// BEHAVIOUR
//  - Reset: state IDLE, tick counter 0, pid_r=pid_y=0, duty=OFFSET, all strobes/flags 0.
//  - Tick counter runs 0..DIV_MUESTREO-1 while enable=1, held at 0 otherwise; tick when count==max.
//  - FSM (Moore outputs): IDLE -(enable)-> WAIT_TICK -(tick)-> ADC_START (adc_start=1) -> ADC_WAIT
//    -(adc_done)-> PID_STROBE (pid_listo=1) -> PID_SETTLE -> PWM_LOAD (duty_load=1) -> WAIT_TICK.
//  - pid_y<=adc_data and pid_r<=ref_in on the edge adc_done is sampled high in ADC_WAIT.
//  - Latency: adc_done in cycle k -> pid_listo cycle k+1 -> duty_load cycle k+3.
//  - duty register updates on PID_SETTLE->PWM_LOAD edge: v=(pid_suma>>>SHIFT)+OFFSET computed
//    at 2*CANT_BITS+1 signed bits; v<0 -> 0; v>2^DUTY_BITS-1 -> 2^DUTY_BITS-1; else v.
//  - tick in any state except WAIT_TICK: sample dropped, overrun<=1; sequence continues.
//  - adc_done outside ADC_WAIT ignored. Tick and PWM_LOAD same cycle: counts as overrun.
//  - enable=0 in any state: next state IDLE, strobes deassert next cycle, duty held,
//    overrun/timeout_err cleared; controller gets no pid_listo for the aborted sample.
//  - rst mid-sequence: immediate return to reset values (async).
// CONFIGURATION
//  SERVO_SEQ_TIMEOUT_EN defined: cycle counter in ADC_WAIT; after TIMEOUT_CYC cycles without
//  adc_done -> timeout_err<=1, return to WAIT_TICK, no pid_listo, duty unchanged.
//  Not defined: ADC_WAIT waits indefinitely; timeout_err tied 0; no counter logic.
// STRUCTURE
//  - Shared package servo_pkg: FSM state encodings (3-bit localparams), duty saturate function,
//    CANT_BITS/DUTY_BITS defaults shared with IPD and PWM blocks.
//  - One sub-module: servo_sat_duty (combinational shift/offset/clamp), reused by manual-mode path.
//  - Tick divider, FSM, capture registers and flags stay in this module.
// TESTING (sim: DIV_MUESTREO=16, SHIFT=4, OFFSET=2048, TIMEOUT_CYC=8)
//  - Nominal: enable=1, ADC answers 3 cycles after adc_start with y=100, suma=160 ->
//    pid_y=100, one pid_listo, duty_load 3 cycles after adc_done, duty=2058; period 16 cycles.
//  - Saturation: suma=+2^30 -> duty=4095; suma=-2^30 -> duty=0; suma=-32768 -> duty=0.
//  - Overrun: ADC delays done 20 cycles -> overrun=1 at second tick, one dropped sample, no extra listo.
//  - Abort: enable=0 during ADC_WAIT, then late adc_done -> no pid_listo, duty held, flags cleared.
//  - Timeout (macro on): adc_done never -> timeout_err=1 after 8 cycles, FSM back to WAIT_TICK;
//    macro off: FSM stays ADC_WAIT, timeout_err=0.
//  - Reset: rst pulsed in PID_SETTLE -> duty=2048, all strobes 0, state IDLE same cycle.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared servo loop definitions: FSM state codes, default widths
// and the duty saturation helper used by the IPD, PWM and sequencer blocks.
package servo_pkg;

    localparam int SERVO_CANT_BITS = 20;
    localparam int SERVO_DUTY_BITS = 12;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_TICK  = 3'd1;
    localparam logic [2:0] ST_ADC_START  = 3'd2;
    localparam logic [2:0] ST_ADC_WAIT   = 3'd3;
    localparam logic [2:0] ST_PID_STROBE = 3'd4;
    localparam logic [2:0] ST_PID_SETTLE = 3'd5;
    localparam logic [2:0] ST_PWM_LOAD   = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        WAIT_TICK  = ST_WAIT_TICK,
        ADC_START  = ST_ADC_START,
        ADC_WAIT   = ST_ADC_WAIT,
        PID_STROBE = ST_PID_STROBE,
        PID_SETTLE = ST_PID_SETTLE,
        PWM_LOAD   = ST_PWM_LOAD
    } state_t;

    localparam int SAT_W = 2 * SERVO_CANT_BITS + 1;
    localparam logic signed [SAT_W-1:0] SAT_MAX =
        SAT_W'((64'd1 << SERVO_DUTY_BITS) - 64'd1);

    // Clamp a widened controller result into the default duty range.
    function automatic logic [SERVO_DUTY_BITS-1:0] sat_duty(
        input logic signed [SAT_W-1:0] v
    );
        if (v[SAT_W-1])
            return '0;
        else if (v > SAT_MAX)
            return '1;
        else
            return v[SERVO_DUTY_BITS-1:0];
    endfunction

endpackage

// File: rtl/servo_sat_duty.sv
// Combinational scale of the signed controller output into a PWM duty:
// arithmetic shift, neutral offset, then clamp to [0, 2^DUTY_BITS-1].
module servo_sat_duty
    import servo_pkg::*;
#(
    parameter int CANT_BITS = SERVO_CANT_BITS,
    parameter int DUTY_BITS = SERVO_DUTY_BITS,
    parameter int SHIFT     = 4,
    parameter int OFFSET    = 2048
) (
    input  logic signed [2*CANT_BITS-1:0] suma,
    output logic        [DUTY_BITS-1:0]   duty
);

    localparam int VW = 2 * CANT_BITS + 1;
    localparam logic signed [VW-1:0] OFS  = VW'(OFFSET);
    localparam logic signed [VW-1:0] MAXV = VW'((64'd1 << DUTY_BITS) - 64'd1);

    logic signed [VW-1:0] ext;
    logic signed [VW-1:0] v;

    // One extra bit of headroom so the offset add cannot wrap.
    always_comb begin
        ext  = {suma[2*CANT_BITS-1], suma};
        v    = (ext >>> SHIFT) + OFS;
        duty = '0;
        if (v[VW-1])
            duty = '0;
        else if (v > MAXV)
            duty = '1;
        else
            duty = v[DUTY_BITS-1:0];
    end

endmodule

// File: rtl/servo_loop_sequencer.sv
// Sample sequencer: tick -> ADC handshake -> controller strobe -> duty load.
// Optional ADC watchdog enabled by defining SERVO_SEQ_TIMEOUT_EN.
module servo_loop_sequencer
    import servo_pkg::*;
#(
    parameter int CANT_BITS    = SERVO_CANT_BITS,
    parameter int DUTY_BITS    = SERVO_DUTY_BITS,
    parameter int DIV_MUESTREO = 50000,
    parameter int SHIFT        = 4,
    parameter int OFFSET       = 2048,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic signed [CANT_BITS-1:0]   ref_in,
    output logic                          adc_start,
    input  logic                          adc_done,
    input  logic signed [CANT_BITS-1:0]   adc_data,
    output logic signed [CANT_BITS-1:0]   pid_r,
    output logic signed [CANT_BITS-1:0]   pid_y,
    output logic                          pid_listo,
    input  logic signed [2*CANT_BITS-1:0] pid_suma,
    output logic        [DUTY_BITS-1:0]   duty,
    output logic                          duty_load,
    output logic                          busy,
    output logic                          overrun,
    output logic                          timeout_err
);

    localparam int CW = $clog2(DIV_MUESTREO);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV_MUESTREO - 1);

    logic [CW-1:0]        cnt;
    logic                 tick;
    state_t               state;
    logic [DUTY_BITS-1:0] duty_sat;

    servo_sat_duty #(
        .CANT_BITS (CANT_BITS),
        .DUTY_BITS (DUTY_BITS),
        .SHIFT     (SHIFT),
        .OFFSET    (OFFSET)
    ) u_sat (
        .suma (pid_suma),
        .duty (duty_sat)
    );

    // Sample period divider, parked at zero while the loop is off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (!enable || cnt == CNT_MAX)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign tick = enable && (cnt == CNT_MAX);
    assign busy = (state != IDLE) && (state != WAIT_TICK);

`ifdef SERVO_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    // Sequencing FSM with registered strobes, captures and sticky flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pid_r     <= '0;
            pid_y     <= '0;
            duty      <= DUTY_BITS'(OFFSET);
            adc_start <= 1'b0;
            pid_listo <= 1'b0;
            duty_load <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERVO_SEQ_TIMEOUT_EN
            timeout_err <= 1'b0;
            to_cnt      <= '0;
`endif
        end else begin
            adc_start <= 1'b0;
            pid_listo <= 1'b0;
            duty_load <= 1'b0;
            if (!enable) begin
                state   <= IDLE;
                overrun <= 1'b0;
`ifdef SERVO_SEQ_TIMEOUT_EN
                timeout_err <= 1'b0;
                to_cnt      <= '0;
`endif
            end else begin
                if (tick && state != WAIT_TICK)
                    overrun <= 1'b1;
                unique case (state)
                    IDLE: state <= WAIT_TICK;
                    WAIT_TICK: begin
                        if (tick) begin
                            state     <= ADC_START;
                            adc_start <= 1'b1;
                        end
                    end
                    ADC_START: begin
                        state <= ADC_WAIT;
`ifdef SERVO_SEQ_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                    ADC_WAIT: begin
                        if (adc_done) begin
                            state     <= PID_STROBE;
                            pid_listo <= 1'b1;
                            pid_y     <= adc_data;
                            pid_r     <= ref_in;
`ifdef SERVO_SEQ_TIMEOUT_EN
                        end else if (to_cnt == TO_MAX) begin
                            state       <= WAIT_TICK;
                            timeout_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
`endif
                        end
                    end
                    PID_STROBE: state <= PID_SETTLE;
                    PID_SETTLE: begin
                        state     <= PWM_LOAD;
                        duty_load <= 1'b1;
                        duty      <= duty_sat;
                    end
                    PWM_LOAD: state <= WAIT_TICK;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_loop_sequencer.sv
// Randomized scoreboard bench for servo_loop_sequencer.
// Covers timeout behaviour for both SERVO_SEQ_TIMEOUT_EN builds.
module tb_servo_loop_sequencer;

    localparam int CB  = 20;
    localparam int DB  = 12;
    localparam int DIV = 16;
    localparam int SH  = 4;
    localparam int OFS = 2048;
    localparam int TO  = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   enable;
    logic signed [CB-1:0]   ref_in;
    logic                   adc_start;
    logic                   adc_done;
    logic signed [CB-1:0]   adc_data;
    logic signed [CB-1:0]   pid_r;
    logic signed [CB-1:0]   pid_y;
    logic                   pid_listo;
    logic signed [2*CB-1:0] pid_suma;
    logic [DB-1:0]          duty;
    logic                   duty_load;
    logic                   busy;
    logic                   overrun;
    logic                   timeout_err;

    servo_loop_sequencer #(
        .CANT_BITS    (CB),
        .DUTY_BITS    (DB),
        .DIV_MUESTREO (DIV),
        .SHIFT        (SH),
        .OFFSET       (OFS),
        .TIMEOUT_CYC  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ref_in      (ref_in),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .pid_r       (pid_r),
        .pid_y       (pid_y),
        .pid_listo   (pid_listo),
        .pid_suma    (pid_suma),
        .duty        (duty),
        .duty_load   (duty_load),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic check(string name, logic signed [63:0] act,
                         logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        longint r;
        longint y;
        int     cyc;
    } cap_t;

    typedef struct {
        longint d;
        int     cyc;
    } dl_t;

    cap_t   cap_q[$];
    dl_t    dl_q[$];
    cap_t   ce;
    dl_t    de;
    longint last_duty;

    // Floor division by 2^SH, add offset, clamp to the duty range.
    function automatic longint ref_duty(longint s);
        longint q;
        longint v;
        longint dv;
        dv = longint'(1) << SH;
        if (s >= 0)
            q = s / dv;
        else
            q = -((-s + dv - 1) / dv);
        v = q + OFS;
        if (v < 0)
            return 0;
        if (v > (longint'(1) << DB) - 1)
            return (longint'(1) << DB) - 1;
        return v;
    endfunction

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (pid_listo) begin
                if (cap_q.size() == 0) begin
                    check("listo_unexpected", pid_listo, 0);
                end else begin
                    ce = cap_q.pop_front();
                    check("pid_r", pid_r, ce.r);
                    check("pid_y", pid_y, ce.y);
                    check("listo_cycle", cyc, ce.cyc);
                end
            end
            if (duty_load) begin
                if (dl_q.size() == 0) begin
                    check("load_unexpected", duty_load, 0);
                end else begin
                    de = dl_q.pop_front();
                    check("duty", duty, de.d);
                    check("load_cycle", cyc, de.cyc);
                end
            end
        end
    end

    task automatic wait_start(output int s);
        bit seen;
        seen = 0;
        s = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (adc_start) begin
                seen = 1;
                s = cyc;
            end
        end
        check("adc_start_seen", adc_start, 1);
    endtask

    task automatic respond(int d, longint y, longint r, longint s,
                           bit push_duty);
        repeat (d) @(posedge clk);
        #1;
        adc_data = CB'(y);
        ref_in   = CB'(r);
        pid_suma = (2*CB)'(s);
        adc_done = 1'b1;
        cap_q.push_back('{r: r, y: y, cyc: cyc + 1});
        if (push_duty) begin
            last_duty = ref_duty(s);
            dl_q.push_back('{d: last_duty, cyc: cyc + 3});
        end
        @(posedge clk);
        #1;
        adc_done = 1'b0;
    endtask

    function automatic longint rnd_sample();
        return longint'($urandom_range(0, (1 << CB) - 1)) - (longint'(1) << (CB - 1));
    endfunction

    function automatic longint rnd_suma();
        longint t;
        case ($urandom_range(0, 2))
            0: return longint'($urandom_range(0, 80000)) - 40000;
            1: begin
                t = {$urandom, $urandom};
                return (t <<< (64 - 2*CB)) >>> (64 - 2*CB);
            end
            default: return longint'($urandom_range(0, 65536)) - 32768;
        endcase
    endfunction

    longint sat_tab[6] = '{longint'(1) << 30, -(longint'(1) << 30),
                           -32768, 32752, 32768, -32753};

    int s, prev;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b0;
        adc_done  = 1'b0;
        ref_in    = '0;
        adc_data  = '0;
        pid_suma  = '0;
        last_duty = OFS;

        repeat (2) @(posedge clk);
        #1;
        check("rst_duty", duty, OFS);
        check("rst_pid_r", pid_r, 0);
        check("rst_pid_y", pid_y, 0);
        check("rst_adc_start", adc_start, 0);
        check("rst_listo", pid_listo, 0);
        check("rst_load", duty_load, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);

        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;

        wait_start(s);
        prev = s;
        respond(3, 100, 50, 160, 1);
        repeat (2) @(posedge clk);
        #1;
        check("nominal_duty", duty, 2058);
        check("nominal_pid_y", pid_y, 100);

        for (int i = 0; i < 18; i++) begin
            wait_start(s);
            check("period", s - prev, DIV);
            prev = s;
            respond($urandom_range(1, 6), rnd_sample(), rnd_sample(),
                    (i < 6) ? sat_tab[i] : rnd_suma(), 1);
        end
        check("no_overrun_yet", overrun, 0);

        wait_start(s);
        repeat (15) @(posedge clk);
        #1;
        check("overrun_before_tick", overrun, 0);
        @(posedge clk);
        #1;
        check("overrun_at_tick", overrun, 1);
        respond(4, rnd_sample(), rnd_sample(), rnd_suma(), 1);
        prev = s;
        wait_start(s);
        check("dropped_sample_period", s - prev, 2 * DIV);
        respond(2, rnd_sample(), rnd_sample(), rnd_suma(), 1);
        check("overrun_sticky", overrun, 1);

        wait_start(s);
        @(posedge clk);
        #1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_overrun_clr", overrun, 0);
        check("abort_timeout_clr", timeout_err, 0);
        adc_done = 1'b1;
        adc_data = 7;
        pid_suma = 40'sd16000;
        @(posedge clk);
        #1;
        adc_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("abort_duty_held", duty, last_duty);
        enable = 1'b1;

`ifdef SERVO_SEQ_TIMEOUT_EN
        wait_start(s);
        repeat (TO) @(posedge clk);
        #1;
        check("to_not_yet", timeout_err, 0);
        check("to_busy_wait", busy, 1);
        @(posedge clk);
        #1;
        check("to_flag", timeout_err, 1);
        check("to_back_wait", busy, 0);
        check("to_duty_held", duty, last_duty);
`else
        wait_start(s);
        repeat (12) @(posedge clk);
        #1;
        check("nto_busy", busy, 1);
        check("nto_flag", timeout_err, 0);
        enable = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
`endif

        wait_start(s);
        respond(2, rnd_sample(), rnd_sample(), 16000, 1);
        wait_start(s);
        respond(2, rnd_sample(), rnd_sample(), 16000, 0);
        @(posedge clk);
        #1;
        check("settle_busy", busy, 1);
        check("settle_duty", duty, 3048);
        rst = 1'b1;
        #1;
        check("async_rst_duty", duty, OFS);
        check("async_rst_busy", busy, 0);
        check("async_rst_pid_y", pid_y, 0);
        check("async_rst_listo", pid_listo, 0);
        check("async_rst_load", duty_load, 0);
        check("async_rst_start", adc_start, 0);
        check("async_rst_flags", {overrun, timeout_err}, 0);
        @(negedge clk);
        rst = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        check("cap_q_empty", cap_q.size(), 0);
        check("dl_q_empty", dl_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
